unidade_busca: RTL and testbench
================================

// Module: unidade_busca
// PURPOSE
//   Instruction-fetch stage that sits directly upstream of the instruction memory/decoder.
//   - Owns the program counter (PC) and drives the byte address `endereco` into the memory.
//   - Captures the returned 32-bit word into an IF/ID pipeline register for the decode stage.
//   - Supports stall, taken-branch redirect (BNE) with flush, and a halt when the PC leaves
//     program memory.
// PARAMETERS
//   PC_INICIAL        32'h0000_0000  byte address fetched after reset
//   TAM_MEM_PALAVRAS  51             words of instruction memory; valid PC < TAM_MEM_PALAVRAS*4
//   NOP               32'h0000_0013  bubble word (addi x0,x0,0) placed in IF/ID on flush/invalid
// PORTS
//   clk                in   1   rising-edge clock
//   reset              in   1   synchronous, active-high reset
//   stall              in   1   hold PC and IF/ID (hazard from later stage)
//   desvio_tomado      in   1   taken branch from execute; 1-cycle pulse
//   alvo_desvio        in   32  branch target byte address (already PC+sext(imm)<<1)
//   instrucao_entrada  in   32  word returned combinationally by memory for `endereco`
//   endereco           out  32  current PC, to instruction memory
//   pc_id              out  32  PC of the instruction held in IF/ID
//   instrucao_id       out  32  instruction held in IF/ID
//   valido_id          out  1   IF/ID holds a real instruction
//   parado             out  1   fetch halted (state FIM)
//   erro_alinhamento   out  1   sticky: redirect target not word-aligned
// BEHAVIOUR
//   Reset (sync, highest priority), applied at the clock edge:
//     endereco=PC_INICIAL, pc_id=0, instrucao_id=NOP, valido_id=0, parado=0,
//     erro_alinhamento=0, state=BUSCA.
//   States:
//     BUSCA  fetching
//     FIM    halted, PC frozen
//   Per-edge priority:
//     reset > desvio_tomado > stall > normal fetch.
//   BUSCA, normal (no stall, no redirect, endereco < TAM_MEM_PALAVRAS*4):
//     IF/ID <= {endereco, instrucao_entrada}, valido_id<=1; endereco<=endereco+4.
//     Latency: word at address A is visible on instrucao_id one edge after endereco==A.
//   BUSCA, stall=1 (no redirect): endereco, pc_id, instrucao_id, valido_id all hold.
//   desvio_tomado=1 (any state, overrides stall):
//     IF/ID flushed: instrucao_id<=NOP, valido_id<=0, pc_id holds.
//     If alvo_desvio[1:0]!=0: erro_alinhamento<=1 (sticky until reset), state<=FIM,
//       endereco holds.
//     Else if alvo_desvio >= TAM_MEM_PALAVRAS*4: state<=FIM, endereco<=alvo_desvio.
//     Else: endereco<=alvo_desvio, state<=BUSCA (also leaves FIM).
//     The word fetched in the redirect cycle is discarded.
//   Range exit: in BUSCA with endereco >= TAM_MEM_PALAVRAS*4 and no redirect:
//     state<=FIM, valido_id<=0, instrucao_id<=NOP, endereco holds.
//     An in-flight valid IF/ID word still reaches decode on the preceding edge.
//   FIM:
//     parado=1 (registered, asserted the edge FIM is entered); endereco/IF/ID hold;
//     stall is ignored. Exit only via reset, or via a redirect to an aligned, in-range
//     target; erro_alinhamento does not block that exit.
//   Arithmetic: endereco+4 is 32-bit modulo; the range check halts long before wrap.
//     Addresses are unsigned compares.
//   Outputs are all registered; no combinational path from inputs to outputs.
// TESTING
//   1. Reset, memory words 0..3 = W0..W3, no stall.
//      -> endereco 0,4,8,12 on successive edges; instrucao_id W0,W1,W2 each 1 edge later;
//         valido_id=1 from edge 1.
//   2. stall=1 for 3 cycles while endereco=8.
//      -> endereco stays 8, instrucao_id/pc_id stay {W1,4} for 3 cycles, then fetch resumes at 8.
//   3. At endereco=16, desvio_tomado=1 with alvo=4, simultaneous with stall=1.
//      -> next edge endereco=4, valido_id=0, instrucao_id=NOP; following edge
//         instrucao_id=W1, pc_id=4.
//   4. Run to endereco=200 (last word) with TAM_MEM_PALAVRAS=51.
//      -> word 50 enters IF/ID, endereco=204, next edge parado=1, valido_id=0, endereco stays 204.
//   5. In FIM, desvio_tomado with alvo=32'h0000_0006.
//      -> erro_alinhamento=1, parado stays 1; then alvo=8 -> parado=0, endereco=8,
//         erro_alinhamento stays 1.
//   6. Assert reset mid-run at endereco=40 with valido_id=1.
//      -> next edge endereco=0, valido_id=0, instrucao_id=NOP, parado=0, erro_alinhamento=0.

Source files
------------

// File: rtl/unidade_busca.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// captures the returned word into the IF/ID register, with stall, redirect and halt.
module unidade_busca #(
    parameter logic [31:0] PC_INICIAL       = 32'h0000_0000,
    parameter int unsigned TAM_MEM_PALAVRAS = 51,
    parameter logic [31:0] NOP              = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        desvio_tomado,
    input  logic [31:0] alvo_desvio,
    input  logic [31:0] instrucao_entrada,
    output logic [31:0] endereco,
    output logic [31:0] pc_id,
    output logic [31:0] instrucao_id,
    output logic        valido_id,
    output logic        parado,
    output logic        erro_alinhamento
);

    localparam logic [31:0] LIMITE_BYTES = 32'(TAM_MEM_PALAVRAS * 4);

    typedef enum logic [0:0] {
        BUSCA = 1'b0,
        FIM   = 1'b1
    } estado_t;

    estado_t     estado_r;
    estado_t     estado_nxt_s;
    logic [31:0] endereco_r;
    logic [31:0] endereco_nxt_s;
    logic [31:0] pc_id_r;
    logic [31:0] pc_id_nxt_s;
    logic [31:0] instrucao_id_r;
    logic [31:0] instrucao_id_nxt_s;
    logic        valido_id_r;
    logic        valido_id_nxt_s;
    logic        parado_r;
    logic        erro_alinhamento_r;
    logic        erro_alinhamento_nxt_s;
    logic        alvo_alinhado_s;
    logic        alvo_em_faixa_s;
    logic        endereco_em_faixa_s;

    function automatic logic alinhado(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

    function automatic logic em_faixa(input logic [31:0] addr);
        return (addr < LIMITE_BYTES);
    endfunction

    assign alvo_alinhado_s     = alinhado(alvo_desvio[1:0]);
    assign alvo_em_faixa_s     = em_faixa(alvo_desvio);
    assign endereco_em_faixa_s = em_faixa(endereco_r);

    // State and pipeline registers; reset is synchronous and dominates everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_r           <= BUSCA;
            endereco_r         <= PC_INICIAL;
            pc_id_r            <= 32'h0000_0000;
            instrucao_id_r     <= NOP;
            valido_id_r        <= 1'b0;
            parado_r           <= 1'b0;
            erro_alinhamento_r <= 1'b0;
        end else begin
            estado_r           <= estado_nxt_s;
            endereco_r         <= endereco_nxt_s;
            pc_id_r            <= pc_id_nxt_s;
            instrucao_id_r     <= instrucao_id_nxt_s;
            valido_id_r        <= valido_id_nxt_s;
            parado_r           <= (estado_nxt_s == FIM);
            erro_alinhamento_r <= erro_alinhamento_nxt_s;
        end
    end

    // Next-state: a redirect decides the state in any state; otherwise BUSCA may halt.
    always_comb begin
        estado_nxt_s = estado_r;
        if (desvio_tomado) begin
            if (!alvo_alinhado_s) begin
                estado_nxt_s = FIM;
            end else if (!alvo_em_faixa_s) begin
                estado_nxt_s = FIM;
            end else begin
                estado_nxt_s = BUSCA;
            end
        end else begin
            case (estado_r)
                BUSCA: begin
                    // A stalled stage holds completely, including a pending range exit.
                    if (stall) begin
                        estado_nxt_s = BUSCA;
                    end else if (!endereco_em_faixa_s) begin
                        estado_nxt_s = FIM;
                    end else begin
                        estado_nxt_s = BUSCA;
                    end
                end
                FIM:     estado_nxt_s = FIM;
                default: estado_nxt_s = FIM;
            endcase
        end
    end

    // Datapath next values: PC and IF/ID contents for each state/input combination.
    always_comb begin
        endereco_nxt_s         = endereco_r;
        pc_id_nxt_s            = pc_id_r;
        instrucao_id_nxt_s     = instrucao_id_r;
        valido_id_nxt_s        = valido_id_r;
        erro_alinhamento_nxt_s = erro_alinhamento_r;
        if (desvio_tomado) begin
            // The word fetched this cycle belongs to the wrong path and is dropped.
            instrucao_id_nxt_s = NOP;
            valido_id_nxt_s    = 1'b0;
            if (!alvo_alinhado_s) begin
                erro_alinhamento_nxt_s = 1'b1;
            end else begin
                endereco_nxt_s = alvo_desvio;
            end
        end else begin
            case (estado_r)
                BUSCA: begin
                    if (stall) begin
                        endereco_nxt_s = endereco_r;
                    end else if (!endereco_em_faixa_s) begin
                        instrucao_id_nxt_s = NOP;
                        valido_id_nxt_s    = 1'b0;
                    end else begin
                        pc_id_nxt_s        = endereco_r;
                        instrucao_id_nxt_s = instrucao_entrada;
                        valido_id_nxt_s    = 1'b1;
                        endereco_nxt_s     = endereco_r + 32'd4;
                    end
                end
                FIM:     endereco_nxt_s = endereco_r;
                default: endereco_nxt_s = endereco_r;
            endcase
        end
    end

    assign endereco         = endereco_r;
    assign pc_id            = pc_id_r;
    assign instrucao_id     = instrucao_id_r;
    assign valido_id        = valido_id_r;
    assign parado           = parado_r;
    assign erro_alinhamento = erro_alinhamento_r;

endmodule

// File: tb/tb_unidade_busca.sv
// Scoreboard bench for unidade_busca: directed scenarios followed by random stimulus,
// expected outputs from an architectural model of the fetch stage.
module tb_unidade_busca;

    localparam logic [31:0] NOP_W  = 32'h0000_0013;
    localparam logic [31:0] LIMITE = 32'd204;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        desvio_tomado;
    logic [31:0] alvo_desvio;
    logic [31:0] instrucao_entrada;
    logic [31:0] endereco;
    logic [31:0] pc_id;
    logic [31:0] instrucao_id;
    logic        valido_id;
    logic        parado;
    logic        erro_alinhamento;

    always #5 clk = ~clk;

    unidade_busca #(
        .PC_INICIAL      (32'h0000_0000),
        .TAM_MEM_PALAVRAS(51),
        .NOP             (NOP_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .desvio_tomado    (desvio_tomado),
        .alvo_desvio      (alvo_desvio),
        .instrucao_entrada(instrucao_entrada),
        .endereco         (endereco),
        .pc_id            (pc_id),
        .instrucao_id     (instrucao_id),
        .valido_id        (valido_id),
        .parado           (parado),
        .erro_alinhamento (erro_alinhamento)
    );

    // Memory larger than the program region so out-of-range fetches return real junk.
    logic [31:0] mem [0:63];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd256) return mem[a[7:2]];
        else return 32'hBAD0_0000 ^ a;
    endfunction

    always_comb instrucao_entrada = mem_word(endereco);

    typedef struct packed {
        logic [31:0] end_e;
        logic [31:0] pc_e;
        logic [31:0] inst_e;
        logic        val_e;
        logic        par_e;
        logic        err_e;
    } esperado_t;

    esperado_t fila[$];
    int total = 0;
    int bad   = 0;

    // Architectural model state
    logic [31:0] m_pc, m_pcid, m_inst;
    logic        m_val, m_halt, m_err;

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h expected=%h", nome, $time, act, exp);
        end
    endtask

    // Monitor: after each edge, compare DUT outputs against the oldest expectation.
    always @(posedge clk) begin
        esperado_t e;
        #1;
        if (fila.size() > 0) begin
            e = fila.pop_front();
            chk("endereco", endereco, e.end_e);
            chk("pc_id", pc_id, e.pc_e);
            chk("instrucao_id", instrucao_id, e.inst_e);
            chk("valido_id", {31'd0, valido_id}, {31'd0, e.val_e});
            chk("parado", {31'd0, parado}, {31'd0, e.par_e});
            chk("erro_alinhamento", {31'd0, erro_alinhamento}, {31'd0, e.err_e});
        end
    end

    // Drive one cycle of inputs, advance the model, queue the expected post-edge outputs.
    task automatic passo(input logic rs, input logic st, input logic br, input logic [31:0] alvo);
        @(posedge clk);
        #2;
        reset         = rs;
        stall         = st;
        desvio_tomado = br;
        alvo_desvio   = alvo;
        if (rs) begin
            m_pc = 32'd0; m_pcid = 32'd0; m_inst = NOP_W;
            m_val = 1'b0; m_halt = 1'b0; m_err = 1'b0;
        end else if (br) begin
            m_inst = NOP_W;
            m_val  = 1'b0;
            if (alvo % 4 != 0) begin
                m_err  = 1'b1;
                m_halt = 1'b1;
            end else begin
                m_pc   = alvo;
                m_halt = (alvo >= LIMITE);
            end
        end else if (m_halt || st) begin
            m_pc = m_pc;
        end else if (m_pc >= LIMITE) begin
            m_halt = 1'b1;
            m_val  = 1'b0;
            m_inst = NOP_W;
        end else begin
            m_pcid = m_pc;
            m_inst = mem_word(m_pc);
            m_val  = 1'b1;
            m_pc   = m_pc + 32'd4;
        end
        fila.push_back('{m_pc, m_pcid, m_inst, m_val, m_halt, m_err});
    endtask

    function automatic logic [31:0] alvo_aleatorio();
        case ($urandom_range(0, 5))
            0: return 32'($urandom_range(0, 50) * 4);
            1: return 32'($urandom_range(0, 50) * 4 + $urandom_range(1, 3));
            2: return 32'($urandom_range(51, 1000) * 4);
            3: return 32'($urandom_range(49, 51) * 4);
            4: return 32'hFFFF_FFFC;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        reset = 1'b1; stall = 1'b0; desvio_tomado = 1'b0; alvo_desvio = 32'd0;
        m_pc = 32'd0; m_pcid = 32'd0; m_inst = NOP_W;
        m_val = 1'b0; m_halt = 1'b0; m_err = 1'b0;

        passo(1'b1, 1'b0, 1'b0, 32'd0);
        passo(1'b1, 1'b0, 1'b0, 32'd0);
        // Sequential fetch to address 8, stall three cycles, resume
        passo(1'b0, 1'b0, 1'b0, 32'd0);
        passo(1'b0, 1'b0, 1'b0, 32'd0);
        repeat (3) passo(1'b0, 1'b1, 1'b0, 32'd0);
        passo(1'b0, 1'b0, 1'b0, 32'd0);
        passo(1'b0, 1'b0, 1'b0, 32'd0);
        // Redirect to 4 at address 16 together with stall
        passo(1'b0, 1'b1, 1'b1, 32'd4);
        passo(1'b0, 1'b0, 1'b0, 32'd0);
        // Run off the end of program memory
        n = 0;
        while (!m_halt && n < 100) begin
            passo(1'b0, 1'b0, 1'b0, 32'd0);
            n++;
        end
        passo(1'b0, 1'b0, 1'b0, 32'd0);
        passo(1'b0, 1'b1, 1'b0, 32'd0);
        // Misaligned redirect in FIM, then a legal exit
        passo(1'b0, 1'b0, 1'b1, 32'h0000_0006);
        passo(1'b0, 1'b0, 1'b0, 32'd0);
        passo(1'b0, 1'b0, 1'b1, 32'd8);
        n = 0;
        while (m_pc != 32'd40 && n < 100) begin
            passo(1'b0, 1'b0, 1'b0, 32'd0);
            n++;
        end
        // Reset mid-run
        passo(1'b1, 1'b0, 1'b0, 32'd0);
        passo(1'b0, 1'b0, 1'b0, 32'd0);
        // Redirect exactly to the last word and to the first out-of-range address
        passo(1'b0, 1'b0, 1'b1, 32'd200);
        repeat (3) passo(1'b0, 1'b0, 1'b0, 32'd0);
        passo(1'b0, 1'b0, 1'b1, 32'd204);
        repeat (2) passo(1'b0, 1'b0, 1'b0, 32'd0);

        for (int k = 0; k < 800; k++) begin
            passo(($urandom_range(0, 99) < 2), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 9) == 0), alvo_aleatorio());
        end

        n = 0;
        while (fila.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        #3;
        total++;
        if (fila.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", fila.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
